// File: rtl/fir3_tap_pkg.sv
// Shared widths, sample/coefficient types and the output saturation helper
// for the three-tap FIR filter.
package fir3_tap_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 8;
    localparam int ACC_W  = DATA_W + COEF_W + 2;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    // Clamp a full-precision accumulator value into the sample range.
    function automatic sample_t saturate(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > hi) begin
            return hi[DATA_W-1:0];
        end else if (v < lo) begin
            return lo[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fir3_tap_add.sv
// Signed, sign-extending two-input adder with one bit of growth.
// APPROX_LSB = 0 gives the exact sum; a non-zero value swaps in a
// lower-part-OR approximate adder over that many low bits, same ports.
module fir3_tap_add #(
    parameter int W          = 24,
    parameter int APPROX_LSB = 0
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W:0]   s
);

    generate
        if (APPROX_LSB == 0) begin : g_exact
            assign s = {a[W-1], a} + {b[W-1], b};
        end else begin : g_approx
            // Low bits are OR'd together and never produce a carry upward.
            for (genvar gi = 0; gi < APPROX_LSB; gi++) begin : g_lsb
                assign s[gi] = a[gi] | b[gi];
            end
            assign s[W:APPROX_LSB] = {a[W-1], a[W-1:APPROX_LSB]}
                                   + {b[W-1], b[W-1:APPROX_LSB]};
        end
    endgenerate

endmodule

// File: rtl/fir3_tap.sv
// Three-tap FIR filter: y <= sat((C0*x + C1*x[n-1] + C2*x[n-2]) >>> SHIFT),
// one new sample every cycle, one cycle of latency, registered output.
module fir3_tap #(
    parameter int DATA_W         = fir3_tap_pkg::DATA_W,
    parameter int COEF_W         = fir3_tap_pkg::COEF_W,
    parameter int COEF0          = 1,
    parameter int COEF1          = 2,
    parameter int COEF2          = 1,
    parameter int SHIFT          = 2,
    parameter int ADD_APPROX_LSB = 0
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y
);
    import fir3_tap_pkg::*;

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = DATA_W + COEF_W + 2;

    logic signed [DATA_W-1:0] d1_reg;
    logic signed [DATA_W-1:0] d2_reg;
    logic signed [DATA_W-1:0] y_reg;
    logic signed [DATA_W-1:0] y_next;

    logic signed [DATA_W-1:0] tap_x [3];
    logic signed [PROD_W-1:0] prod  [3];
    logic signed [PROD_W:0]   sum01;
    logic signed [SUM_W-1:0]  acc;
    logic signed [SUM_W-1:0]  shifted;

    assign tap_x[0] = x;
    assign tap_x[1] = d1_reg;
    assign tap_x[2] = d2_reg;

    // Constant-coefficient products; positive powers of two become shifts,
    // which give exactly the same bits as the multiply.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tap
            localparam int C_INT = (gi == 0) ? COEF0 : ((gi == 1) ? COEF1 : COEF2);
            localparam logic signed [COEF_W-1:0] C_VAL = COEF_W'(C_INT);
            if (C_INT > 0 && ((C_INT & (C_INT - 1)) == 0)) begin : g_shift
                assign prod[gi] = PROD_W'(tap_x[gi]) <<< $clog2(C_INT);
            end else begin : g_mult
                assign prod[gi] = PROD_W'(tap_x[gi]) * PROD_W'(C_VAL);
            end
        end
    endgenerate

    fir3_tap_add #(
        .W          (PROD_W),
        .APPROX_LSB (ADD_APPROX_LSB)
    ) u_add01 (
        .a (prod[0]),
        .b (prod[1]),
        .s (sum01)
    );

    fir3_tap_add #(
        .W          (PROD_W + 1),
        .APPROX_LSB (ADD_APPROX_LSB)
    ) u_add2 (
        .a (sum01),
        .b ((PROD_W + 1)'(prod[2])),
        .s (acc)
    );

    // Arithmetic shift floors toward minus infinity; no rounding is applied.
    assign shifted = acc >>> SHIFT;

    // Clamp to the output range; the package helper covers the default widths.
    generate
        if (DATA_W == fir3_tap_pkg::DATA_W && COEF_W == fir3_tap_pkg::COEF_W) begin : g_sat_pkg
            assign y_next = saturate(shifted);
        end else begin : g_sat_gen
            localparam logic signed [SUM_W-1:0] SAT_HI =
                {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
            localparam logic signed [SUM_W-1:0] SAT_LO =
                {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
            assign y_next = (shifted > SAT_HI) ? SAT_HI[DATA_W-1:0] :
                            (shifted < SAT_LO) ? SAT_LO[DATA_W-1:0] :
                                                 shifted[DATA_W-1:0];
        end
    endgenerate

    // Delay line and output register; reset wipes all sample history.
    always_ff @(posedge clk) begin
        if (rstN) begin
            d1_reg <= '0;
            d2_reg <= '0;
            y_reg  <= '0;
        end else begin
            d1_reg <= x;
            d2_reg <= d1_reg;
            y_reg  <= y_next;
        end
    end

    assign y = y_reg;

endmodule

// File: tb/tb_fir3_tap.sv
// Self-checking bench for fir3_tap: directed scenarios plus randomized
// stimulus against a history-queue reference model.
module tb_fir3_tap;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] y_sat;

    int checks   = 0;
    int failures = 0;

    // Samples accepted since the last reset, newest first.
    int hist[$];

    always #5 clk = ~clk;

    fir3_tap dut (
        .clk  (clk),
        .rstN (rst),
        .x    (x),
        .y    (y)
    );

    fir3_tap #(.COEF1(4)) dut_sat (
        .clk  (clk),
        .rstN (rst),
        .x    (x),
        .y    (y_sat)
    );

    // Filter response from the samples seen since reset; absent taps are 0.
    function automatic int ref_y(input int c1);
        longint t[3];
        longint s;
        longint q;
        for (int i = 0; i < 3; i++) t[i] = (i < hist.size()) ? longint'(hist[i]) : 0;
        s = t[0] + longint'(c1) * t[1] + t[2];
        q = s / 4;
        if (s < 0 && (s % 4) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    // Apply one sample (or reset) across one rising edge, then settle.
    task automatic cycle(input int xv, input bit r);
        x   = DW'(xv);
        rst = r;
        @(posedge clk);
        if (r) begin
            hist.delete();
        end else begin
            hist.push_front(xv);
            if (hist.size() > 3) void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        int exp_rel[4] = '{1, 2, 1, 0};
        int xin_rel[4] = '{4, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            cycle(1234, 1'b1);
            checks++;
            if (int'(y) !== 0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: y=%0d required 0", i, y);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(xin_rel[i], 1'b0);
            checks++;
            if (int'(y) !== exp_rel[i]) begin
                failures++;
                $display("FAIL reset_release[%0d]: y=%0d required %0d", i, y, exp_rel[i]);
            end
        end
    endtask

    task automatic test_impulse();
        int xin[4] = '{1000, 0, 0, 0};
        int exp_y[4] = '{250, 500, 250, 0};
        for (int i = 0; i < 3; i++) cycle(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(xin[i], 1'b0);
            checks++;
            if (int'(y) !== exp_y[i]) begin
                failures++;
                $display("FAIL impulse[%0d]: y=%0d required %0d", i, y, exp_y[i]);
            end
        end
    endtask

    task automatic test_step();
        int exp_up[4] = '{1000, 3000, 4000, 4000};
        int e;
        for (int i = 0; i < 3; i++) cycle(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(4000, 1'b0);
            checks++;
            if (int'(y) !== exp_up[i]) begin
                failures++;
                $display("FAIL step_up[%0d]: y=%0d required %0d", i, y, exp_up[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            cycle(-32768, 1'b0);
            e = ref_y(2);
            checks++;
            if (int'(y) !== e) begin
                failures++;
                $display("FAIL step_neg[%0d]: y=%0d required %0d", i, y, e);
            end
        end
        checks++;
        if (int'(y) !== -32768) begin
            failures++;
            $display("FAIL step_neg_final: y=%0d required -32768", y);
        end
    endtask

    task automatic test_truncation();
        int xin[8] = '{1, 0, 0, -1, 0, 0, 0, 0};
        int exp_y[8] = '{0, 0, 0, -1, -1, -1, 0, 0};
        for (int i = 0; i < 3; i++) cycle(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(xin[i], 1'b0);
            checks++;
            if (int'(y) !== exp_y[i]) begin
                failures++;
                $display("FAIL truncation[%0d]: y=%0d required %0d", i, y, exp_y[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int e;
        cycle(0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(32767, 1'b0);
            e = ref_y(4);
            checks++;
            if (int'(y_sat) !== e) begin
                failures++;
                $display("FAIL sat_pos[%0d]: y=%0d required %0d", i, y_sat, e);
            end
        end
        checks++;
        if (int'(y_sat) !== 32767) begin
            failures++;
            $display("FAIL sat_pos_final: y=%0d required 32767", y_sat);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(-32768, 1'b0);
            e = ref_y(4);
            checks++;
            if (int'(y_sat) !== e) begin
                failures++;
                $display("FAIL sat_neg[%0d]: y=%0d required %0d", i, y_sat, e);
            end
        end
        checks++;
        if (int'(y_sat) !== -32768) begin
            failures++;
            $display("FAIL sat_neg_final: y=%0d required -32768", y_sat);
        end
    endtask

    task automatic test_midstream_reset();
        bit rin[6]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int exp_y[6] = '{1000, 3000, 0, 1000, 3000, 4000};
        cycle(0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(4000, rin[i]);
            checks++;
            if (int'(y) !== exp_y[i]) begin
                failures++;
                $display("FAIL midstream_reset[%0d]: y=%0d required %0d", i, y, exp_y[i]);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        int xv;
        int e;
        int es;
        bit r;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       xv = 32767;
                1:       xv = -32768;
                2:       xv = int'($urandom_range(0, 15)) - 8;
                default: xv = int'($urandom_range(0, 65535)) - 32768;
            endcase
            r = ($urandom_range(0, 31) == 0);
            cycle(xv, r);
            e  = ref_y(2);
            es = ref_y(4);
            checks++;
            if (int'(y) !== e) begin
                failures++;
                $display("FAIL random[%0d]: x=%0d rst=%0d y=%0d required %0d", i, xv, r, y, e);
            end
            checks++;
            if (int'(y_sat) !== es) begin
                failures++;
                $display("FAIL random_sat[%0d]: x=%0d rst=%0d y=%0d required %0d", i, xv, r, y_sat, es);
            end
        end
    endtask

    initial begin
        x   = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_impulse();
        test_step();
        test_truncation();
        test_saturation();
        test_midstream_reset();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir3_tap.md
FIR3_TAP -- requirements
Module: fir3_tap

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 DATA_W, default 16, SHALL set the width of the signed input and output samples.
REQ-003 COEF_W, default 8, SHALL set the width of the signed tap coefficients.
REQ-004 COEF0, default 1, SHALL be the weight applied to the current sample x[n].
REQ-005 COEF1, default 2, SHALL be the weight applied to x[n-1].
REQ-006 COEF2, default 1, SHALL be the weight applied to x[n-2].
REQ-007 SHIFT, default 2, SHALL be the arithmetic right-shift (scaling) applied to the accumulated sum.
REQ-008 clk: input, 1 bit, SHALL be the clock; every register updates on its rising edge.
REQ-009 rstN: input, 1 bit, SHALL be the synchronous reset, active-high (1 = reset), sampled on the clk rising edge.
REQ-010 x: input, DATA_W bits, SHALL be the signed two's-complement sample, sampled on every clk rising edge with no valid qualifier.
REQ-011 y: output, DATA_W bits, SHALL be the signed two's-complement filtered sample, driven directly from a register.

Function
REQ-012 Delay registers d1 and d2 SHALL hold x[n-1] and x[n-2].
- Each edge without reset: d1<=x, d2<=d1.
REQ-013 Each edge without reset SHALL update y as y <= sat((COEF0*x + COEF1*d1 + COEF2*d2) >>> SHIFT).
REQ-014 Latency SHALL be exactly 1 cycle.
- The x sampled at edge n contributes to y visible after edge n.
- That same x contributes again after edges n+1 and n+2.
REQ-015 Products and the sum SHALL be computed at full precision, with no intermediate overflow.
- Accumulator width ACC_W = DATA_W + COEF_W + 2, signed.
REQ-016 Scaling SHALL be an arithmetic shift, i.e. truncation toward minus infinity, with no rounding.
- Example: -1 >>> 2 = -1.
REQ-017 The shifted result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Default range: [-32768, 32767].
- No wrap-around.
REQ-018 The block SHALL accept a new sample on every cycle, back to back, with no stall or handshake.
REQ-019 The defaults give the response (x[n] + 2x[n-1] + x[n-2]) / 4, unity DC gain.

Reset
REQ-020 While rstN=1 at a clk rising edge, d1, d2 and y SHALL all load 0.
- x is ignored during reset.
REQ-021 A reset asserted mid-stream SHALL clear all history.
- The first y after reset release SHALL depend only on samples taken after release.
- Missing taps are treated as 0.
REQ-022 y SHALL be 0 from the first reset edge until the first non-reset edge.

Structure
REQ-023 Package fir3_tap_pkg SHALL hold:
- DATA_W, COEF_W and ACC_W constants;
- the sample_t and coef_t signed typedefs;
- a saturate function from ACC_W to DATA_W bits.
REQ-024 The adder tree SHALL be a separate sub-module, fir3_tap_add, a signed sign-extending adder with a (W+1)-bit output.
- It is instantiated twice.
- Exact and approximate adder variants SHALL be swappable behind the same ports.
REQ-025 Multiplication by constant coefficients MAY use shift-and-add when a coefficient is a power of two, provided the results are bit-identical to the multiply.

Verification
REQ-026 Reset: hold rstN=1 for 10 cycles with x=1234 -> y=0 throughout; after release, d1 and d2 start from 0.
REQ-027 Impulse: x=1000 for one cycle, then 0 -> y=250, 500, 250, then 0.
REQ-028 Step: x=4000 held -> y=1000, 3000, 4000, 4000...; step to -32768 held -> y settles at -32768 with no overflow.
REQ-029 Truncation: impulse x=1 -> y=0, 0, 0; impulse x=-1 -> y=-1, -1, -1.
REQ-030 Saturation: with COEF1=4, x=32767 held -> y saturates at 32767; x=-32768 held -> y=-32768.
REQ-031 Mid-stream reset: step x=4000, assert rstN for 1 cycle after 2 outputs -> y=0, then 1000, 3000, 4000.
